// File: rtl/fetch_unit_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH  = 8;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc}; entry 0 is always the head so outputs are plain registers.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstbar,
  input  logic                   flush,
  input  logic                   push,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  input  logic [ADDR_WIDTH-1:0]  push_pc,
  input  logic                   pop,
  output logic [1:0]             count,
  output logic [INSTR_WIDTH-1:0] head_instr,
  output logic [ADDR_WIDTH-1:0]  head_pc
);

  logic [INSTR_WIDTH-1:0] tail_instr;
  logic [ADDR_WIDTH-1:0]  tail_pc;

  // Callers only pop when count!=0 and only push when there is room after the pop.
  always_ff @(posedge clk) begin
    if (!rstbar) begin
      count      <= '0;
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end else begin
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end else begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and fetch FSM, buffers fetched words for the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rstbar,
  input  logic                   start,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  input  logic                   halt_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rwbar,
  output logic [INSTR_WIDTH-1:0] mem_d_in,
  input  logic [INSTR_WIDTH-1:0] mem_d_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   halted
);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            count;
  logic                  pop, fetch;

  assign mem_addr    = pc;
  assign mem_rwbar   = 1'b1;
  assign mem_d_in    = '0;
  assign instr_valid = (count != 2'd0);
  assign halted      = (state == HALT) && (count == 2'd0);

  // A pop during a redirect is discarded by the flush, so it need not be masked here.
  assign pop   = instr_valid && instr_ready;
  assign fetch = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!redirect_valid && start) state_next = RUN;
      RUN:  if (halt_req)                 state_next = HALT;
      HALT: if (redirect_valid)           state_next = RUN;
      default:                            state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstbar) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid) pc <= redirect_addr;
      else if (fetch)     pc <= pc + 1'b1;
    end
  end

  fetch_buffer #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_buffer (
    .clk        (clk),
    .rstbar     (rstbar),
    .flush      (redirect_valid),
    .push       (fetch),
    .push_instr (mem_d_out),
    .push_pc    (pc),
    .pop        (pop),
    .count      (count),
    .head_instr (instr_data),
    .head_pc    (instr_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a memory holding mem[i] = i ^ 8'hA5.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rstbar, start, redirect_valid, halt_req, instr_ready;
  logic [7:0] redirect_addr, mem_addr, mem_d_in, mem_d_out, instr_data, instr_pc;
  logic       mem_rwbar, instr_valid, halted;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_d_out = mem_addr ^ 8'hA5;

  fetch_unit #(
    .ADDR_WIDTH  (8),
    .INSTR_WIDTH (8),
    .RESET_PC    (8'h00)
  ) dut (
    .clk            (clk),
    .rstbar         (rstbar),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .mem_addr       (mem_addr),
    .mem_rwbar      (mem_rwbar),
    .mem_d_in       (mem_d_in),
    .mem_d_out      (mem_d_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic v, input logic [7:0] pc,
                             input logic [7:0] d);
    n_assert++;
    assert (instr_valid === v) else begin
      n_fail++;
      $error("FAIL %s.valid observed=%b expected=%b", tag, instr_valid, v);
    end
    if (v) begin
      n_assert++;
      assert (instr_pc === pc) else begin
        n_fail++;
        $error("FAIL %s.pc observed=%h expected=%h", tag, instr_pc, pc);
      end
      n_assert++;
      assert (instr_data === d) else begin
        n_fail++;
        $error("FAIL %s.data observed=%h expected=%h", tag, instr_data, d);
      end
    end
  endtask

  task automatic expect_ctl(input string tag, input logic h, input logic [7:0] a);
    n_assert++;
    assert (halted === h) else begin
      n_fail++;
      $error("FAIL %s.halted observed=%b expected=%b", tag, halted, h);
    end
    n_assert++;
    assert (mem_addr === a) else begin
      n_fail++;
      $error("FAIL %s.mem_addr observed=%h expected=%h", tag, mem_addr, a);
    end
    n_assert++;
    assert (mem_rwbar === 1'b1 && mem_d_in === 8'h00) else begin
      n_fail++;
      $error("FAIL %s.mem_ctl observed=%b/%h expected=1/00", tag, mem_rwbar, mem_d_in);
    end
  endtask

  initial begin
    rstbar = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
    halt_req = 1'b0; instr_ready = 1'b0;
    step(); step();
    expect_ctl("rst", 1'b0, 8'h00);
    n_assert++;
    assert (instr_valid === 1'b0 && instr_data === 8'h00 && instr_pc === 8'h00) else begin
      n_fail++;
      $error("FAIL rst.outs observed=%b/%h/%h expected=0/00/00", instr_valid, instr_data, instr_pc);
    end
    rstbar = 1'b1;
    step();
    expect_head("idle", 1'b0, 8'h00, 8'h00);
    expect_ctl("idle", 1'b0, 8'h00);

    // 1: streaming with ready held high
    instr_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    expect_head("t1.e0", 1'b0, 8'h00, 8'h00);
    step(); expect_head("t1.a", 1'b1, 8'h00, 8'hA5);
    step(); expect_head("t1.b", 1'b1, 8'h01, 8'hA4);
    step(); expect_head("t1.c", 1'b1, 8'h02, 8'hA7);
    expect_ctl("t1", 1'b0, 8'h03);

    // 2: backpressure from a fresh start
    rstbar = 1'b0; instr_ready = 1'b0;
    step(); rstbar = 1'b1;
    expect_head("t2.rst", 1'b0, 8'h00, 8'h00);
    start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    expect_head("t2.fill", 1'b1, 8'h00, 8'hA5);
    step(); step(); step();
    expect_head("t2.hold", 1'b1, 8'h00, 8'hA5);
    expect_ctl("t2.hold", 1'b0, 8'h02);
    instr_ready = 1'b1;
    step(); expect_head("t2.r1", 1'b1, 8'h01, 8'hA4);
    step(); expect_head("t2.r2", 1'b1, 8'h02, 8'hA7);
    step(); expect_head("t2.r3", 1'b1, 8'h03, 8'hA6);

    // 3: redirect with two entries buffered
    redirect_valid = 1'b1; redirect_addr = 8'hF0;
    step(); redirect_valid = 1'b0;
    expect_head("t3.flush", 1'b0, 8'h00, 8'h00);
    expect_ctl("t3.flush", 1'b0, 8'hF0);
    step(); expect_head("t3.a", 1'b1, 8'hF0, 8'h55);
    step(); expect_head("t3.b", 1'b1, 8'hF1, 8'h54);

    // 4: PC wrap
    redirect_valid = 1'b1; redirect_addr = 8'hFE;
    step(); redirect_valid = 1'b0;
    expect_head("t4.flush", 1'b0, 8'h00, 8'h00);
    step(); expect_head("t4.a", 1'b1, 8'hFE, 8'h5B);
    step(); expect_head("t4.b", 1'b1, 8'hFF, 8'h5A);
    step(); expect_head("t4.c", 1'b1, 8'h00, 8'hA5);
    step(); expect_head("t4.d", 1'b1, 8'h01, 8'hA4);

    // 5: halt with a full buffer, drain, start ignored, redirect resumes
    instr_ready = 1'b0;
    step();
    halt_req = 1'b1;
    step(); halt_req = 1'b0;
    expect_head("t5.full", 1'b1, 8'h01, 8'hA4);
    expect_ctl("t5.full", 1'b0, 8'h03);
    instr_ready = 1'b1;
    step(); expect_head("t5.d1", 1'b1, 8'h02, 8'hA7);
    expect_ctl("t5.d1", 1'b0, 8'h03);
    step(); expect_head("t5.d2", 1'b0, 8'h00, 8'h00);
    expect_ctl("t5.d2", 1'b1, 8'h03);
    start = 1'b1;
    step(); start = 1'b0;
    expect_ctl("t5.start", 1'b1, 8'h03);
    redirect_valid = 1'b1; redirect_addr = 8'h10;
    step(); redirect_valid = 1'b0;
    expect_ctl("t5.redir", 1'b0, 8'h10);
    expect_head("t5.redir", 1'b0, 8'h00, 8'h00);
    step(); expect_head("t5.a", 1'b1, 8'h10, 8'hB5);

    // 6: reset mid-stream
    rstbar = 1'b0;
    step(); rstbar = 1'b1;
    expect_head("t6.rst", 1'b0, 8'h00, 8'h00);
    expect_ctl("t6.rst", 1'b0, 8'h00);
    step(); step();
    expect_head("t6.idle", 1'b0, 8'h00, 8'h00);
    expect_ctl("t6.idle", 1'b0, 8'h00);
    start = 1'b1;
    step(); start = 1'b0;
    step(); expect_head("t6.a", 1'b1, 8'h00, 8'hA5);

    // 7: redirect in IDLE beats start; then redirect+halt in RUN
    rstbar = 1'b0;
    step(); rstbar = 1'b1;
    start = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h20;
    step(); start = 1'b0; redirect_valid = 1'b0;
    expect_ctl("t7.idle", 1'b0, 8'h20);
    step(); expect_head("t7.idle", 1'b0, 8'h00, 8'h00);
    expect_ctl("t7.still", 1'b0, 8'h20);
    start = 1'b1;
    step(); start = 1'b0;
    step(); expect_head("t7.a", 1'b1, 8'h20, 8'h85);
    redirect_valid = 1'b1; redirect_addr = 8'h30; halt_req = 1'b1;
    step(); redirect_valid = 1'b0; halt_req = 1'b0;
    expect_head("t7.rh", 1'b0, 8'h00, 8'h00);
    expect_ctl("t7.rh", 1'b1, 8'h30);
    step(); expect_ctl("t7.rh2", 1'b1, 8'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
